// File: rtl/hu_stall_ctrl.sv
// rtl/hu_stall_ctrl.sv - pipeline hazard sequencer: stall/flush controls, MDU launch, memory timeout
//
// Purpose:
//   This block covers the hazards that forwarding cannot resolve:
//   load-use, multi-cycle MDU operations, data-memory wait states and
//   taken-branch flushes. It drives the F/D/E/M/W pipeline-register
//   holds and clears.
//
// Timing:
//   Stall, flush and mdu_go outputs are combinational from the current
//   state and the inputs. The pipeline registers act on the same edge.
//   While rst_n is low, all of these outputs are forced to 0.
//
// Parameters:
//   MEM_TIMEOUT      MEM_WAIT cycles before mem_timeout_err sets (1..65535)
//
// Ports:
//   clk, rst_n       clock (rising edge), asynchronous active-low reset
//   Rs1_D, Rs2_D     D-stage source registers
//   rs1_used_D, rs2_used_D
//                    D-stage instruction reads Rs1/Rs2
//   Rd_E             E-stage destination register
//   RegWrite_E, MemRead_E
//                    E-stage writes a register / is a load
//   branch_taken_E   E-stage branch/jump resolved taken
//   mdu_start_E      E-stage holds an MDU op (level)
//   mdu_done         MDU result valid (single-cycle pulse)
//   dmem_req_M, dmem_ready
//                    M-stage memory request / memory ready
//   Stall_F..Stall_M hold the stage register
//   Flush_D..Flush_W load a bubble into the stage register
//   mdu_go           one-cycle MDU launch pulse
//   mem_timeout_err  sticky memory timeout flag
//
// Optional feature (macro HU_PERF_CNT_EN):
//   Adds 32-bit wrapping counters perf_stall_cnt, perf_flush_cnt and perf_lu_cnt.

module hu_stall_ctrl #(
  parameter int unsigned MEM_TIMEOUT = 255
) (
  input  logic        clk,
  input  logic        rst_n,
  input  logic [4:0]  Rs1_D,
  input  logic [4:0]  Rs2_D,
  input  logic        rs1_used_D,
  input  logic        rs2_used_D,
  input  logic [4:0]  Rd_E,
  input  logic        RegWrite_E,
  input  logic        MemRead_E,
  input  logic        branch_taken_E,
  input  logic        mdu_start_E,
  input  logic        mdu_done,
  input  logic        dmem_req_M,
  input  logic        dmem_ready,
  output logic        Stall_F,
  output logic        Stall_D,
  output logic        Stall_E,
  output logic        Stall_M,
  output logic        Flush_D,
  output logic        Flush_E,
  output logic        Flush_M,
  output logic        Flush_W,
  output logic        mdu_go,
  output logic        mem_timeout_err
`ifdef HU_PERF_CNT_EN
  ,
  output logic [31:0] perf_stall_cnt,
  output logic [31:0] perf_flush_cnt,
  output logic [31:0] perf_lu_cnt
`endif
);

  typedef enum logic [1:0] {
    RUN      = 2'd0,
    MDU_WAIT = 2'd1,
    MEM_WAIT = 2'd2
  } state_e;

  localparam logic [15:0] TMO_LAST = 16'(MEM_TIMEOUT - 1);

  state_e      state_q, state_d;
  logic        done_q, done_d;    // mdu_done seen while memory held the pipe
  logic        pend_q, pend_d;    // MDU op launched, result not yet returned
  logic [15:0] cnt_q, cnt_d;
  logic        err_q, err_d;

  logic mem_hold;
  logic mdu_hold;
  logic lu;
  logic mdu_go_c;

  always_comb begin : hazard_detect
    mem_hold = dmem_req_M & ~dmem_ready;
    // Once the result is in hand (live or latched), the E stage may advance.
    mdu_hold = ((state_q == RUN) & mdu_start_E & ~mdu_done) |
               ((state_q == MDU_WAIT) & ~done_q & ~mdu_done);
    lu = MemRead_E & RegWrite_E & (Rd_E != 5'd0) &
         ((rs1_used_D & (Rd_E == Rs1_D)) | (rs2_used_D & (Rd_E == Rs2_D)));
    // Launch only from RUN; later cycles of a held op are in MDU_WAIT.
    mdu_go_c = (state_q == RUN) & mdu_start_E & ~mem_hold;
  end

  always_comb begin : hazard_outputs
    Stall_F = 1'b0;
    Stall_D = 1'b0;
    Stall_E = 1'b0;
    Stall_M = 1'b0;
    Flush_D = 1'b0;
    Flush_E = 1'b0;
    Flush_M = 1'b0;
    Flush_W = 1'b0;
    mdu_go  = 1'b0;
    if (rst_n) begin
      mdu_go = mdu_go_c;
      if (mem_hold) begin
        // Whole pipe frozen. A taken branch waits in E and flushes later.
        Stall_F = 1'b1;
        Stall_D = 1'b1;
        Stall_E = 1'b1;
        Stall_M = 1'b1;
        Flush_W = 1'b1;
      end else if (mdu_hold) begin
        Stall_F = 1'b1;
        Stall_D = 1'b1;
        Stall_E = 1'b1;
        Flush_M = 1'b1;
      end else if (branch_taken_E) begin
        // The D instruction is wrong-path, so a load-use on it is moot.
        Flush_D = 1'b1;
        Flush_E = 1'b1;
      end else if (lu) begin
        Stall_F = 1'b1;
        Stall_D = 1'b1;
        Flush_E = 1'b1;
      end
    end
  end

  always_comb begin : next_state
    state_d = state_q;
    pend_d  = (pend_q | mdu_go_c) & ~mdu_done;
    cnt_d   = 16'd0;
    err_d   = err_q;
    case (state_q)
      RUN: begin
        if (mem_hold) begin
          state_d = MEM_WAIT;
        end else if (mdu_go_c & ~mdu_done) begin
          state_d = MDU_WAIT;
        end
      end
      MDU_WAIT: begin
        if ((mdu_done | done_q) & ~mem_hold) begin
          state_d = RUN;
        end
      end
      MEM_WAIT: begin
        if (~mem_hold) begin
          state_d = (pend_q & ~mdu_done & ~done_q) ? MDU_WAIT : RUN;
        end
      end
      default: state_d = RUN;
    endcase

    if (state_d == RUN) begin
      done_d = 1'b0;
    end else begin
      done_d = done_q | (mdu_done & mem_hold);
    end

    if ((state_q == MEM_WAIT) && (state_d == MEM_WAIT)) begin
      cnt_d = cnt_q + 16'd1;
    end
    // The flag only reports the timeout. Stalling continues until memory answers.
    if ((state_q == MEM_WAIT) && mem_hold && (cnt_q == TMO_LAST)) begin
      err_d = 1'b1;
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin : state_regs
    if (!rst_n) begin
      state_q <= RUN;
      done_q  <= 1'b0;
      pend_q  <= 1'b0;
      cnt_q   <= 16'd0;
      err_q   <= 1'b0;
    end else begin
      state_q <= state_d;
      done_q  <= done_d;
      pend_q  <= pend_d;
      cnt_q   <= cnt_d;
      err_q   <= err_d;
    end
  end

  assign mem_timeout_err = err_q;

`ifdef HU_PERF_CNT_EN
  logic [31:0] perf_stall_q, perf_stall_d;
  logic [31:0] perf_flush_q, perf_flush_d;
  logic [31:0] perf_lu_q, perf_lu_d;
  logic        lu_bubble;

  // A load-use bubble is counted only when no higher-priority hazard masks it.
  assign lu_bubble = rst_n & ~mem_hold & ~mdu_hold & ~branch_taken_E & lu;

  always_comb begin : perf_next
    perf_stall_d = perf_stall_q + {31'd0, Stall_F};
    perf_flush_d = perf_flush_q + {31'd0, Flush_D};
    perf_lu_d    = perf_lu_q + {31'd0, lu_bubble};
  end

  always_ff @(posedge clk or negedge rst_n) begin : perf_regs
    if (!rst_n) begin
      perf_stall_q <= 32'd0;
      perf_flush_q <= 32'd0;
      perf_lu_q    <= 32'd0;
    end else begin
      perf_stall_q <= perf_stall_d;
      perf_flush_q <= perf_flush_d;
      perf_lu_q    <= perf_lu_d;
    end
  end

  assign perf_stall_cnt = perf_stall_q;
  assign perf_flush_cnt = perf_flush_q;
  assign perf_lu_cnt    = perf_lu_q;
`endif

endmodule
